// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, derived widths and FSM state type for the instruction cache
package icache_pkg;
   localparam int ICACHE_SETS      = 16;
   localparam int ICACHE_LINE_BITS = 256;
   localparam int BMEM_BEAT_BITS   = 64;
   localparam int BEATS            = ICACHE_LINE_BITS / BMEM_BEAT_BITS;
   localparam int OFS_W            = $clog2(ICACHE_LINE_BITS / 8);
   localparam int IDX_W            = $clog2(ICACHE_SETS);
   localparam int TAG_W            = 32 - OFS_W - IDX_W;
   localparam int CNT_W            = $clog2(BEATS);
   typedef enum logic [1:0] {IDLE, REQ, FILL} icache_state_t;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: tag/valid/data flop arrays with combinational read and single write port
module icache_line_array
   import icache_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [IDX_W-1:0]            rd_idx,
   output logic                        rd_valid,
   output logic [TAG_W-1:0]            rd_tag,
   output logic [ICACHE_LINE_BITS-1:0] rd_data,
   input  logic                        we,
   input  logic [IDX_W-1:0]            wr_idx,
   input  logic [TAG_W-1:0]            wr_tag,
   input  logic [ICACHE_LINE_BITS-1:0] wr_data
);
   logic [ICACHE_SETS-1:0]      valid_q, valid_d;
   logic [TAG_W-1:0]            tag_q  [ICACHE_SETS];
   logic [TAG_W-1:0]            tag_d  [ICACHE_SETS];
   logic [ICACHE_LINE_BITS-1:0] data_q [ICACHE_SETS];
   logic [ICACHE_LINE_BITS-1:0] data_d [ICACHE_SETS];

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[rd_idx];

   // a fill overwrites its set unconditionally
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (we) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = wr_tag;
         data_d[wr_idx]  = wr_data;
      end
   end

   // only valid bits need reset; stale tags/data are masked by valid
   always_ff @(posedge clk) begin
      valid_q <= rst ? '0 : valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
   end
endmodule

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped read-only icache, 0-cycle hits, burst line fill on miss
module icache_responder
   import icache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic        imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   output logic [31:0] bmem_addr,
   output logic        bmem_read,
   input  logic        bmem_ready,
   input  logic [31:0] bmem_raddr,
   input  logic [63:0] bmem_rdata,
   input  logic        bmem_rvalid
);
   icache_state_t               state_q, state_d;
   logic [31:0]                 fill_addr_q, fill_addr_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [ICACHE_LINE_BITS-1:0] buf_q, buf_d, line_w;
   logic                        rd_valid, hit, beat_ok, last;
   logic [TAG_W-1:0]            rd_tag;
   logic [ICACHE_LINE_BITS-1:0] rd_data;
   logic                        unused_addr_lsb;

   assign unused_addr_lsb = ^imem_addr[1:0];
   assign hit        = rd_valid && rd_tag == imem_addr[31 -: TAG_W];
   assign imem_resp  = state_q == IDLE && imem_rmask && hit;
   assign imem_rdata = imem_resp ? rd_data[imem_addr[OFS_W-1:2] * 32 +: 32] : '0;
   assign bmem_read  = state_q == REQ;
   assign bmem_addr  = bmem_read ? fill_addr_q : '0;
   assign beat_ok    = state_q == FILL && bmem_rvalid && bmem_raddr == fill_addr_q;
   assign last       = beat_ok && cnt_q == CNT_W'(BEATS - 1);

   icache_line_array u_array (
      .clk     (clk),
      .rst     (rst),
      .rd_idx  (imem_addr[OFS_W +: IDX_W]),
      .rd_valid(rd_valid),
      .rd_tag  (rd_tag),
      .rd_data (rd_data),
      .we      (last),
      .wr_idx  (fill_addr_q[OFS_W +: IDX_W]),
      .wr_tag  (fill_addr_q[31 -: TAG_W]),
      .wr_data (line_w)
   );

   // next-state: miss latches line address, REQ waits for ready, FILL collects tagged beats
   always_comb begin
      state_d             = state_q;
      fill_addr_d         = fill_addr_q;
      cnt_d               = cnt_q;
      line_w              = buf_q;
      line_w[cnt_q * BMEM_BEAT_BITS +: BMEM_BEAT_BITS] = bmem_rdata;
      buf_d               = beat_ok ? line_w : buf_q;
      case (state_q)
         IDLE: if (imem_rmask && !hit) begin
            fill_addr_d = {imem_addr[31:OFS_W], OFS_W'(0)};
            state_d     = REQ;
         end
         REQ: if (bmem_ready) begin
            cnt_d   = '0;
            state_d = FILL;
         end
         FILL: if (beat_ok) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = last ? IDLE : FILL;
         end
         default: state_d = IDLE;
      endcase
   end

   // control state with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         fill_addr_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         fill_addr_q <= fill_addr_d;
         cnt_q       <= cnt_d;
      end
   end

   // line buffer contents are don't-care until a fill writes them
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed scenario tests for icache_responder
module tb_icache_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic        imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] bmem_addr;
   logic        bmem_read;
   logic        bmem_ready;
   logic [31:0] bmem_raddr;
   logic [63:0] bmem_rdata;
   logic        bmem_rvalid;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   icache_responder dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_rmask (imem_rmask),
      .imem_rdata (imem_rdata),
      .imem_resp  (imem_resp),
      .bmem_addr  (bmem_addr),
      .bmem_read  (bmem_read),
      .bmem_ready (bmem_ready),
      .bmem_raddr (bmem_raddr),
      .bmem_rdata (bmem_rdata),
      .bmem_rvalid(bmem_rvalid)
   );

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a == 32'h6000_0000 ? 32'h0000_0093 :
             a == 32'h6000_0004 ? 32'h0000_0013 : a ^ 32'hDEAD_0000;
   endfunction

   function automatic logic [63:0] beat_of(input logic [31:0] line, input int b);
      return {word_of(line + 32'(8 * b + 4)), word_of(line + 32'(8 * b))};
   endfunction

   task automatic serve_fill(input logic [31:0] line, input int nready, input int nbeats, input int stale);
      int t = 0;
      while (bmem_read !== 1'b1 && t < 20) begin
         @(negedge clk); #1; t++;
      end
      checks++;
      if (bmem_read !== 1'b1) begin
         failures++;
         $display("FAIL fill_start line=%h bmem_read=%b required 1", line, bmem_read);
         return;
      end
      for (int i = 0; i < nready; i++) begin
         bmem_rvalid = stale > 0;
         bmem_raddr  = line ^ 32'h40;
         bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
         checks++;
         if (bmem_read !== 1'b1 || bmem_addr !== line || imem_resp !== 1'b0) begin
            failures++;
            $display("FAIL req_hold cyc=%0d read=%b addr=%h resp=%b required 1 %h 0", i, bmem_read, bmem_addr, imem_resp, line);
         end
         @(negedge clk); #1;
      end
      bmem_rvalid = 1'b0;
      checks++;
      if (bmem_read !== 1'b1 || bmem_addr !== line) begin
         failures++;
         $display("FAIL req_accept read=%b addr=%h required 1 %h", bmem_read, bmem_addr, line);
      end
      bmem_ready = 1'b1;
      @(negedge clk);
      bmem_ready = 1'b0;
      #1;
      checks++;
      if (bmem_read !== 1'b0 || imem_resp !== 1'b0) begin
         failures++;
         $display("FAIL single_accept read=%b resp=%b required 0 0", bmem_read, imem_resp);
      end
      for (int s = 0; s < stale; s++) begin
         bmem_rvalid = 1'b1;
         bmem_raddr  = line ^ 32'h40;
         bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
         @(negedge clk); #1;
      end
      for (int b = 0; b < nbeats; b++) begin
         bmem_rvalid = 1'b1;
         bmem_raddr  = line;
         bmem_rdata  = beat_of(line, b);
         #1;
         checks++;
         if (imem_resp !== 1'b0) begin
            failures++;
            $display("FAIL fill_resp beat=%0d resp=%b required 0", b, imem_resp);
         end
         @(negedge clk);
      end
      bmem_rvalid = 1'b0;
      #1;
   endtask

   task automatic run_hits(input logic [31:0] line, input int first);
      for (int w = first; w < 8; w++) begin
         imem_addr = line + 32'(4 * w);
         #1;
         checks++;
         if (imem_resp !== 1'b1 || imem_rdata !== word_of(imem_addr) || bmem_read !== 1'b0) begin
            failures++;
            $display("FAIL hit addr=%h resp=%b rdata=%h read=%b required 1 %h 0", imem_addr, imem_resp, imem_rdata, bmem_read, word_of(imem_addr));
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1; imem_rmask = 1'b0; imem_addr = '0;
      bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
      @(negedge clk); #1;
      checks++;
      if (imem_resp !== 1'b0 || bmem_read !== 1'b0 || bmem_addr !== 32'h0 || imem_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_out resp=%b read=%b addr=%h rdata=%h required 0 0 0 0", imem_resp, bmem_read, bmem_addr, imem_rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (imem_resp !== 1'b0 || bmem_read !== 1'b0 || bmem_addr !== 32'h0) begin
         failures++;
         $display("FAIL post_reset resp=%b read=%b addr=%h required 0 0 0", imem_resp, bmem_read, bmem_addr);
      end
   endtask

   task automatic test_cold_miss;
      imem_rmask = 1'b1;
      imem_addr  = 32'h6000_0000;
      #1;
      checks++;
      if (imem_resp !== 1'b0) begin
         failures++;
         $display("FAIL cold_miss_resp resp=%b required 0", imem_resp);
      end
      serve_fill(32'h6000_0000, 0, 4, 0);
      checks++;
      if (imem_resp !== 1'b1 || imem_rdata !== 32'h0000_0093) begin
         failures++;
         $display("FAIL cold_miss_done resp=%b rdata=%h required 1 00000093", imem_resp, imem_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_sequential_hits;
      run_hits(32'h6000_0000, 1);
   endtask

   task automatic test_conflict;
      imem_addr = 32'h6000_0200;
      #1;
      checks++;
      if (imem_resp !== 1'b0) begin
         failures++;
         $display("FAIL conflict_miss resp=%b required 0", imem_resp);
      end
      serve_fill(32'h6000_0200, 0, 4, 0);
      run_hits(32'h6000_0200, 0);
      imem_addr = 32'h6000_0000;
      #1;
      checks++;
      if (imem_resp !== 1'b0) begin
         failures++;
         $display("FAIL conflict_evict resp=%b required 0", imem_resp);
      end
      serve_fill(32'h6000_0000, 0, 4, 0);
      checks++;
      if (imem_resp !== 1'b1 || imem_rdata !== 32'h0000_0093) begin
         failures++;
         $display("FAIL conflict_refill resp=%b rdata=%h required 1 00000093", imem_resp, imem_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      imem_addr = 32'h6000_0020;
      #1;
      serve_fill(32'h6000_0020, 5, 4, 0);
      checks++;
      if (imem_resp !== 1'b1 || imem_rdata !== 32'hBEAD_0020) begin
         failures++;
         $display("FAIL bp_done resp=%b rdata=%h required 1 bead0020", imem_resp, imem_rdata);
      end
      @(negedge clk);
      run_hits(32'h6000_0020, 0);
   endtask

   task automatic test_reset_mid_fill;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      imem_addr = 32'h6000_0000;
      #1;
      serve_fill(32'h6000_0000, 0, 2, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      imem_addr = 32'h6000_0040;
      #1;
      checks++;
      if (imem_resp !== 1'b0 || bmem_read !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset resp=%b read=%b required 0 0", imem_resp, bmem_read);
      end
      serve_fill(32'h6000_0040, 1, 4, 2);
      checks++;
      if (imem_resp !== 1'b1 || imem_rdata !== 32'hBEAD_0040) begin
         failures++;
         $display("FAIL stale_fill resp=%b rdata=%h required 1 bead0040", imem_resp, imem_rdata);
      end
      @(negedge clk);
      run_hits(32'h6000_0040, 0);
      imem_addr = 32'h6000_0000;
      #1;
      checks++;
      if (imem_resp !== 1'b0) begin
         failures++;
         $display("FAIL reset_cleared resp=%b required 0", imem_resp);
      end
      serve_fill(32'h6000_0000, 0, 4, 0);
      checks++;
      if (imem_resp !== 1'b1 || imem_rdata !== 32'h0000_0093) begin
         failures++;
         $display("FAIL refill_after_reset resp=%b rdata=%h required 1 00000093", imem_resp, imem_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_idle;
      imem_rmask = 1'b0;
      imem_addr  = 32'h6000_0000;
      #1;
      checks++;
      if (imem_resp !== 1'b0 || bmem_read !== 1'b0 || imem_rdata !== 32'h0) begin
         failures++;
         $display("FAIL idle_valid resp=%b read=%b rdata=%h required 0 0 0", imem_resp, bmem_read, imem_rdata);
      end
      @(negedge clk);
      imem_addr = 32'h6000_0400;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         checks++;
         if (imem_resp !== 1'b0 || bmem_read !== 1'b0) begin
            failures++;
            $display("FAIL idle_nofill cyc=%0d resp=%b read=%b required 0 0", i, imem_resp, bmem_read);
         end
      end
      imem_rmask = 1'b1;
      imem_addr  = 32'h6000_0000;
      #1;
      checks++;
      if (imem_resp !== 1'b1 || imem_rdata !== 32'h0000_0093) begin
         failures++;
         $display("FAIL idle_resume resp=%b rdata=%h required 1 00000093", imem_resp, imem_rdata);
      end
   endtask

   initial begin
      test_reset;
      test_cold_miss;
      test_sequential_hits;
      test_conflict;
      test_backpressure;
      test_reset_mid_fill;
      test_idle;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Responder end of the fetch-side instruction memory interface: accepts `imem_addr`/`imem_rmask` from the fetch stage and returns `imem_rdata`/`imem_resp`.
- Direct-mapped, read-only instruction cache with flop-based arrays, so hits are combinational (0-cycle).
- Misses fill one line over the burst memory port (`bmem_*`).
- Sits between `fetch_stage` and the memory arbiter.

Parameters:
- SETS, 16, number of lines (power of 2); index = addr[4+log2(SETS):5].
- LINE_BITS, 256, line size (8 words); offset = addr[4:0].
- BEAT_BITS, 64, burst data width; BEATS = LINE_BITS/BEAT_BITS = 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_addr  in  32  fetch address; bits [1:0] ignored
- imem_rmask  in  1  read request, held high continuously by fetch
- imem_rdata  out  32  instruction word at imem_addr
- imem_resp  out  1  rdata valid this cycle; fetch advances PC on this edge
- bmem_addr  out  32  line-aligned fill address
- bmem_read  out  1  fill request
- bmem_ready  in  1  memory accepts request this cycle
- bmem_raddr  in  32  line address tagging each returned beat
- bmem_rdata  in  64  beat data, beat 0 = lowest address
- bmem_rvalid  in  1  beat valid

Behaviour:
- Reset (synchronous, active-high, on clk): state=IDLE; all valid bits=0; beat counter=0; line buffer don't-care.
- Outputs during and immediately after reset: imem_resp=0, bmem_read=0, bmem_addr=0, imem_rdata=0 when resp=0.
- Tag = addr[31:5+log2(SETS)] (23 bits at default).
- hit = valid[idx] & (tag_arr[idx]==tag).
- IDLE:
  - imem_resp = imem_rmask & hit, combinational, same cycle.
  - imem_rdata = word addr[4:2] of data_arr[idx].
  - Back-to-back hits give 1 response per cycle.
  - imem_rmask & ~hit: latch line address {addr[31:5],5'b0} into fill_addr; next state REQ.
- REQ:
  - bmem_read=1, bmem_addr=fill_addr, both held until the cycle bmem_ready=1; then go to FILL, beat counter=0.
  - imem_resp=0.
- FILL:
  - bmem_read=0.
  - Each cycle with bmem_rvalid & (bmem_raddr==fill_addr): store beat into line buffer slot [counter], then counter++.
  - Beats with mismatched raddr are discarded; they are stale from a fill aborted by reset.
  - On the beat where counter==BEATS-1, at that edge:
    - write the full line to data_arr[idx(fill_addr)];
    - write tag_arr;
    - set valid=1;
    - go to IDLE.
  - imem_resp=0 throughout FILL.
- Miss latency: resp asserts combinationally in the first IDLE cycle after the last-beat edge, provided imem_addr is unchanged. Fetch holds the address while resp=0.
- Address changing while in REQ/FILL: the fill completes to fill_addr regardless. The new address is looked up on return to IDLE.
- bmem_rvalid in IDLE or REQ: ignored.
- Replacement: direct-mapped; a fill overwrites the set unconditionally. No dirty state, no writes from the core.
- imem_rmask=0 in IDLE: resp=0, no fill started.
- Reset mid-fill: return to IDLE, valids cleared, remaining beats discarded by state and raddr mismatch.

Decomposition:
- Shared package (rv32i_types or a new cache_pkg): ICACHE_SETS, ICACHE_LINE_BITS, BMEM_BEAT_BITS, derived index/tag widths, and an enum icache_state_t {IDLE, REQ, FILL}.
- One natural sub-module: icache_line_array, holding the tag/valid/data flop arrays with a combinational read port and a 1-write port with synchronous reset of valids.
- The FSM and line buffer stay in icache_responder.

Test Plan:
- Cold miss:
  - Stimulus: after reset, rmask=1, addr=0x60000000.
  - Required: bmem_read=1 with bmem_addr=0x60000000 until ready; then 4 beats with raddr=0x60000000, beat0 data=0x00000013_00000093.
  - Required: resp=1 with rdata=0x00000093 in the cycle after the 4th beat.
- Sequential hit:
  - Stimulus: after the fill, addr=0x60000004 next cycle.
  - Required: resp=1 in the same cycle, rdata=0x00000013, no bmem_read.
  - Stimulus: addrs 0x60000008..0x6000001C on consecutive cycles.
  - Required: resp every cycle.
- Conflict:
  - Stimulus: addr=0x60000200 (set 0, different tag).
  - Required: miss and refill; then addr 0x60000000 misses again.
- Ready backpressure:
  - Stimulus: hold bmem_ready=0 for 5 cycles.
  - Required: bmem_read and bmem_addr stable for all 5 cycles, single acceptance, no resp.
- Reset mid-fill:
  - Stimulus: assert rst after 2 beats; deliver the 2 remaining stale beats (raddr=0x60000000) while the new miss to 0x60000040 is in REQ/FILL.
  - Required: stale beats ignored; line 0x60000040 filled only from beats tagged with raddr=0x60000040.
  - Required: 0x60000000 misses after reset.
- Idle:
  - Stimulus: rmask=0 with a valid line present.
  - Required: resp=0, bmem_read=0.
